// File: rtl/alu_regfile_wb_if.sv
// alu_regfile_wb_if: bundles the instruction handshake, load port, operand
// outputs, ALU result buses and writeback/flag outputs of alu_regfile_wb.
// The slave modport is the stage itself. The master modport is the
// controller/ALU side that surrounds it.
interface alu_regfile_wb_if;
   // instruction request channel
   logic       op_valid;
   logic       op_ready;
   logic [2:0] op_code;
   logic [1:0] rs1;
   logic [1:0] rs2;
   logic [1:0] rd;

   // register preload channel
   logic       ld_valid;
   logic       ld_ready;
   logic [1:0] ld_addr;
   logic [7:0] ld_data;

   // operands presented to the ALU
   logic [7:0] R1;
   logic [7:0] R2;

   // parallel ALU result buses
   logic [7:0] Addition;
   logic [7:0] MultiplyByTwo;
   logic [7:0] DivideByTwo;
   logic [7:0] And;
   logic [7:0] Or;
   logic [7:0] Compare;
   logic       AdditionOverflow;
   logic       MultiplyByTwoOverflow;

   // writeback and status
   logic       wb_valid;
   logic [7:0] wb_data;
   logic       flag_z;
   logic       flag_v;

   modport slave (
      input  op_valid, op_code, rs1, rs2, rd,
      input  ld_valid, ld_addr, ld_data,
      input  Addition, MultiplyByTwo, DivideByTwo, And, Or, Compare,
      input  AdditionOverflow, MultiplyByTwoOverflow,
      output op_ready, ld_ready,
      output R1, R2,
      output wb_valid, wb_data, flag_z, flag_v
   );

   modport master (
      output op_valid, op_code, rs1, rs2, rd,
      output ld_valid, ld_addr, ld_data,
      output Addition, MultiplyByTwo, DivideByTwo, And, Or, Compare,
      output AdditionOverflow, MultiplyByTwoOverflow,
      input  op_ready, ld_ready,
      input  R1, R2,
      input  wb_valid, wb_data, flag_z, flag_v
   );
endinterface

// File: rtl/alu_regfile_wb.sv
// alu_regfile_wb: operand-supply and writeback stage around a combinational
// ALU. It holds a small register file and latches two source operands onto
// R1/R2. One clock later it picks the ALU result bus named by the latched
// opcode, commits it to the destination register and updates the Z/V flags.
// The IDLE -> EXEC -> WRITE sequence gives one instruction per three cycles.
// A preload port writes the register file whenever no writeback can occur.
module alu_regfile_wb #(
   parameter int NREGS = 4
) (
   input logic             clk,
   input logic             rst_n,
   alu_regfile_wb_if.slave bus
);

   localparam int DATA_W = 8;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_EXEC  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SHL = 3'b001;
   localparam logic [2:0] OP_SHR = 3'b010;
   localparam logic [2:0] OP_AND = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_CMP = 3'b101;
   localparam logic [2:0] OP_MOV = 3'b110;
   localparam logic [2:0] OP_NOP = 3'b111;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];
   logic [DATA_W-1:0] r1_q, r1_d;
   logic [DATA_W-1:0] r2_q, r2_d;
   logic [2:0]        opc_q, opc_d;
   logic [1:0]        rd_q, rd_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic              wb_valid_q, wb_valid_d;
   logic              flag_z_q, flag_z_d;
   logic              flag_v_q, flag_v_d;

   logic              op_fire;
   logic              ld_fire;
   logic [DATA_W-1:0] result;
   logic              result_ovf;

   // Pick the ALU bus matching the opcode; MOV passes the second operand.
   function automatic logic [DATA_W-1:0] select_result(
      input logic [2:0]        opc,
      input logic [DATA_W-1:0] add_r,
      input logic [DATA_W-1:0] shl_r,
      input logic [DATA_W-1:0] shr_r,
      input logic [DATA_W-1:0] and_r,
      input logic [DATA_W-1:0] or_r,
      input logic [DATA_W-1:0] cmp_r,
      input logic [DATA_W-1:0] mov_r
   );
      logic [DATA_W-1:0] r;
      case (opc)
         OP_ADD:  r = add_r;
         OP_SHL:  r = shl_r;
         OP_SHR:  r = shr_r;
         OP_AND:  r = and_r;
         OP_OR:   r = or_r;
         OP_CMP:  r = cmp_r;
         OP_MOV:  r = mov_r;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Only ADD and SHL report overflow; every other op clears V.
   function automatic logic select_ovf(
      input logic [2:0] opc,
      input logic       add_v,
      input logic       shl_v
   );
      logic v;
      case (opc)
         OP_ADD:  v = add_v;
         OP_SHL:  v = shl_v;
         default: v = 1'b0;
      endcase
      return v;
   endfunction

   // Handshakes depend on state alone, so there is no path from op_valid to op_ready.
   assign bus.op_ready = (state_q == S_IDLE);
   assign bus.ld_ready = (state_q != S_WRITE);

   assign op_fire = bus.op_valid && (state_q == S_IDLE);
   assign ld_fire = bus.ld_valid && (state_q != S_WRITE);

   assign bus.R1       = r1_q;
   assign bus.R2       = r2_q;
   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.flag_z   = flag_z_q;
   assign bus.flag_v   = flag_v_q;

   // Result mux from the latched opcode; the ALU has settled on R1/R2 since EXEC.
   always_comb begin
      result     = select_result(opc_q, bus.Addition, bus.MultiplyByTwo,
                                 bus.DivideByTwo, bus.And, bus.Or,
                                 bus.Compare, r2_q);
      result_ovf = select_ovf(opc_q, bus.AdditionOverflow,
                              bus.MultiplyByTwoOverflow);
   end

   // Next state for the FSM, operand latches, register file and writeback outputs.
   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      r1_d       = r1_q;
      r2_d       = r2_q;
      opc_d      = opc_q;
      rd_d       = rd_q;
      wb_data_d  = wb_data_q;
      wb_valid_d = 1'b0;
      flag_z_d   = flag_z_q;
      flag_v_d   = flag_v_q;

      // A load is never allowed in WRITE, so it cannot collide with the commit below.
      if (ld_fire) begin
         regs_d[bus.ld_addr] = bus.ld_data;
      end

      case (state_q)
         S_IDLE: begin
            if (op_fire) begin
               state_d = S_EXEC;
               // Operands come from regs_q, so a load on this same edge does not bypass.
               r1_d    = regs_q[bus.rs1];
               r2_d    = regs_q[bus.rs2];
               opc_d   = bus.op_code;
               rd_d    = bus.rd;
            end
         end
         S_EXEC: begin
            state_d = S_WRITE;
         end
         S_WRITE: begin
            state_d = S_IDLE;
            if (opc_q != OP_NOP) begin
               regs_d[rd_q] = result;
               wb_data_d    = result;
               wb_valid_d   = 1'b1;
               flag_z_d     = (result == '0);
               flag_v_d     = result_ovf;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // All state clears immediately on reset, which aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
         r1_q       <= '0;
         r2_q       <= '0;
         opc_q      <= OP_NOP;
         rd_q       <= '0;
         wb_data_q  <= '0;
         wb_valid_q <= 1'b0;
         flag_z_q   <= 1'b0;
         flag_v_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         r1_q       <= r1_d;
         r2_q       <= r2_d;
         opc_q      <= opc_d;
         rd_q       <= rd_d;
         wb_data_q  <= wb_data_d;
         wb_valid_q <= wb_valid_d;
         flag_z_q   <= flag_z_d;
         flag_v_q   <= flag_v_d;
      end
   end

endmodule

// File: tb/tb_alu_regfile_wb.sv
// tb_alu_regfile_wb: testbench for alu_regfile_wb. A behavioural ALU drives
// the result buses from R1/R2. A register-file/flag model predicts every
// writeback.
module tb_alu_regfile_wb;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   alu_regfile_wb_if bus ();

   alu_regfile_wb #(.NREGS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // behavioural ALU: shifts act on the second operand
   always_comb begin
      {bus.AdditionOverflow, bus.Addition}           = {1'b0, bus.R1} + {1'b0, bus.R2};
      {bus.MultiplyByTwoOverflow, bus.MultiplyByTwo} = {bus.R2, 1'b0};
      bus.DivideByTwo = bus.R2 >> 1;
      bus.And         = bus.R1 & bus.R2;
      bus.Or          = bus.R1 | bus.R2;
      bus.Compare     = (bus.R1 == bus.R2) ? 8'h00 : 8'hFF;
   end

   // reference state
   logic [7:0] mregs [4];
   logic [7:0] m_data;
   logic       m_z;
   logic       m_v;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] data;
      logic       z;
      logic       v;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
      m_data = 8'h00;
      m_z    = 1'b0;
      m_v    = 1'b0;
   endtask

   // Instruction semantics in plain integer arithmetic. The operands are read
   // before the same-edge load is applied, and the commit is applied last.
   task automatic model_op(input logic [2:0] opc, input logic [1:0] s1, input logic [1:0] s2,
                           input logic [1:0] d, input bit ld_en, input logic [1:0] la,
                           input logic [7:0] ldat, output bit e_wb);
      int a, b, r;
      bit ovf;
      a   = mregs[s1];
      b   = mregs[s2];
      r   = 0;
      ovf = 1'b0;
      case (opc)
         3'd0: begin r = a + b; ovf = (r > 255); end
         3'd1: begin r = b * 2; ovf = (r > 255); end
         3'd2: r = b / 2;
         3'd3: r = a & b;
         3'd4: r = a | b;
         3'd5: r = (a == b) ? 0 : 255;
         3'd6: r = b;
         default: r = 0;
      endcase
      r = r % 256;
      if (ld_en) mregs[la] = ldat;
      e_wb = (opc != 3'd7);
      if (e_wb) begin
         mregs[d] = r[7:0];
         m_data   = r[7:0];
         m_z      = (r == 0);
         m_v      = ovf;
      end
   endtask

   task automatic load(input logic [1:0] a, input logic [7:0] d);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      tick();
      bus.ld_valid = 1'b0;
      mregs[a] = d;
   endtask

   // Issue one instruction, optionally with a load on the accept edge. Check
   // the 3-cycle handshake and return at the commit cycle.
   task automatic exec_op(input string tag, input logic [2:0] opc, input logic [1:0] s1,
                          input logic [1:0] s2, input logic [1:0] d, input bit ld_en,
                          input logic [1:0] la, input logic [7:0] ldat);
      bit e_wb;
      int n;
      n = 0;
      while (bus.op_ready !== 1'b1 && n < 8) begin
         tick();
         n++;
      end
      chk({tag, ".ready_wait"}, bus.op_ready, 1);
      model_op(opc, s1, s2, d, ld_en, la, ldat, e_wb);
      bus.op_valid = 1'b1;
      bus.op_code  = opc;
      bus.rs1      = s1;
      bus.rs2      = s2;
      bus.rd       = d;
      bus.ld_valid = ld_en;
      bus.ld_addr  = la;
      bus.ld_data  = ldat;
      tick();
      bus.op_valid = 1'b0;
      bus.ld_valid = 1'b0;
      chk({tag, ".exec_op_ready"}, bus.op_ready, 0);
      chk({tag, ".exec_ld_ready"}, bus.ld_ready, 1);
      tick();
      chk({tag, ".write_op_ready"}, bus.op_ready, 0);
      chk({tag, ".write_ld_ready"}, bus.ld_ready, 0);
      chk({tag, ".write_wb_valid"}, bus.wb_valid, 0);
      tick();
      chk({tag, ".wb_valid"}, bus.wb_valid, e_wb);
      chk({tag, ".wb_data"}, bus.wb_data, m_data);
      chk({tag, ".flag_z"}, bus.flag_z, m_z);
      chk({tag, ".flag_v"}, bus.flag_v, m_v);
      chk({tag, ".op_ready_back"}, bus.op_ready, 1);
   endtask

   // Read a register by moving it onto itself.
   task automatic peek(input string tag, input logic [1:0] r, input logic [7:0] exp);
      exec_op({tag, ".peek"}, 3'd6, 2'd0, r, r, 1'b0, 2'd0, 8'h00);
      chk({tag, ".value"}, bus.wb_data, exp);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, ".R1"}, bus.R1, 0);
      chk({tag, ".R2"}, bus.R2, 0);
      chk({tag, ".wb_data"}, bus.wb_data, 0);
      chk({tag, ".wb_valid"}, bus.wb_valid, 0);
      chk({tag, ".flag_z"}, bus.flag_z, 0);
      chk({tag, ".flag_v"}, bus.flag_v, 0);
      chk({tag, ".op_ready"}, bus.op_ready, 1);
      chk({tag, ".ld_ready"}, bus.ld_ready, 1);
   endtask

   initial begin
      tbl[0]  = '{3'd0, 8'd100, 8'd20,  8'd120, 1'b0, 1'b0};
      tbl[1]  = '{3'd0, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1};
      tbl[2]  = '{3'd0, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0};
      tbl[3]  = '{3'd3, 8'h0F,  8'hF0,  8'h00,  1'b1, 1'b0};
      tbl[4]  = '{3'd4, 8'h0F,  8'hF0,  8'hFF,  1'b0, 1'b0};
      tbl[5]  = '{3'd1, 8'h00,  8'h81,  8'h02,  1'b0, 1'b1};
      tbl[6]  = '{3'd1, 8'h00,  8'h40,  8'h80,  1'b0, 1'b0};
      tbl[7]  = '{3'd2, 8'h00,  8'h81,  8'h40,  1'b0, 1'b0};
      tbl[8]  = '{3'd5, 8'd5,   8'd5,   8'h00,  1'b1, 1'b0};
      tbl[9]  = '{3'd5, 8'd5,   8'd6,   8'hFF,  1'b0, 1'b0};
      tbl[10] = '{3'd6, 8'd7,   8'h3C,  8'h3C,  1'b0, 1'b0};
      tbl[11] = '{3'd2, 8'h00,  8'h01,  8'h00,  1'b1, 1'b0};

      bus.op_valid = 1'b0;
      bus.op_code  = 3'd0;
      bus.rs1      = 2'd0;
      bus.rs2      = 2'd0;
      bus.rd       = 2'd0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = 2'd0;
      bus.ld_data  = 8'h00;
      rst_n        = 1'b0;
      model_reset();
      #2;
      check_reset("rst_init");
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // table-driven: r0=a, r1=b, op rs1=0 rs2=1 rd=2
      for (int i = 0; i < 12; i++) begin
         load(2'd0, tbl[i].a);
         load(2'd1, tbl[i].b);
         exec_op("tbl", tbl[i].op, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
         chk($sformatf("tbl%0d.data", i), bus.wb_data, tbl[i].data);
         chk($sformatf("tbl%0d.z", i), bus.flag_z, tbl[i].z);
         chk($sformatf("tbl%0d.v", i), bus.flag_v, tbl[i].v);
      end

      // ADD then MOV of its result
      load(2'd0, 8'd100);
      load(2'd1, 8'd20);
      exec_op("add", 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2'd0, 8'h00);
      chk("add.data", bus.wb_data, 120);
      exec_op("mov", 3'd6, 2'd0, 2'd2, 2'd3, 1'b0, 2'd0, 8'h00);
      chk("mov.data", bus.wb_data, 120);

      // AND to zero into r0
      load(2'd0, 8'h0F);
      load(2'd1, 8'hF0);
      exec_op("and0", 3'd3, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 8'h00);
      chk("and0.z", bus.flag_z, 1);
      peek("and0_r0", 2'd0, 8'h00);

      // SHL with overflow then NOP
      load(2'd1, 8'h81);
      exec_op("shl", 3'd1, 2'd0, 2'd1, 2'd1, 1'b0, 2'd0, 8'h00);
      chk("shl.data", bus.wb_data, 8'h02);
      chk("shl.v", bus.flag_v, 1);
      exec_op("nop", 3'd7, 2'd0, 2'd1, 2'd1, 1'b0, 2'd0, 8'h00);
      chk("nop.wb_valid", bus.wb_valid, 0);
      chk("nop.data_kept", bus.wb_data, 8'h02);
      chk("nop.v_kept", bus.flag_v, 1);
      peek("nop_r1", 2'd1, 8'h02);

      // load on the accept edge does not bypass into the operands
      load(2'd0, 8'h11);
      exec_op("ldacc", 3'd6, 2'd0, 2'd0, 2'd3, 1'b1, 2'd0, 8'h55);
      chk("ldacc.data", bus.wb_data, 8'h11);
      peek("ldacc_r0", 2'd0, 8'h55);

      // load request during WRITE waits until IDLE
      load(2'd1, 8'h22);
      load(2'd2, 8'h33);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'd6;
      bus.rs1      = 2'd0;
      bus.rs2      = 2'd0;
      bus.rd       = 2'd3;
      tick();
      bus.op_valid = 1'b0;
      tick();
      bus.ld_valid = 1'b1;
      bus.ld_addr  = 2'd1;
      bus.ld_data  = 8'h99;
      #1;
      chk("defer.ld_ready_write", bus.ld_ready, 0);
      tick();
      chk("defer.ld_ready_idle", bus.ld_ready, 1);
      chk("defer.wb_valid", bus.wb_valid, 1);
      chk("defer.wb_data", bus.wb_data, 8'h55);
      bus.ld_addr = 2'd2;
      bus.ld_data = 8'hA5;
      tick();
      bus.ld_valid = 1'b0;
      mregs[3] = 8'h55;
      mregs[2] = 8'hA5;
      m_data   = 8'h55;
      m_z      = 1'b0;
      m_v      = 1'b0;
      peek("defer_r1", 2'd1, 8'h22);
      peek("defer_r2", 2'd2, 8'hA5);

      // back-to-back: r1 = r0 + r1 with op_valid held high
      load(2'd0, 8'd1);
      load(2'd1, 8'd0);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'd0;
      bus.rs1      = 2'd0;
      bus.rs2      = 2'd1;
      bus.rd       = 2'd1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (k == 11) bus.op_valid = 1'b0;
         chk($sformatf("b2b%0d.wb_valid", k), bus.wb_valid, (k % 3 == 2));
         chk($sformatf("b2b%0d.op_ready", k), bus.op_ready, (k % 3 == 2));
         if (k % 3 == 2) chk($sformatf("b2b%0d.data", k), bus.wb_data, k / 3 + 1);
      end
      mregs[1] = 8'd4;
      m_data   = 8'd4;
      m_z      = 1'b0;
      m_v      = 1'b0;
      peek("b2b_r1", 2'd1, 8'd4);

      // randomized ops and loads against the model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) load(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
         exec_op($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      end

      // reset in the middle of a pending ADD
      load(2'd0, 8'd100);
      load(2'd1, 8'd20);
      bus.op_valid = 1'b1;
      bus.op_code  = 3'd0;
      bus.rs1      = 2'd0;
      bus.rs2      = 2'd1;
      bus.rd       = 2'd2;
      tick();
      bus.op_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset("rst_exec");
      #2;
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rst_after%0d.wb_valid", k), bus.wb_valid, 0);
      end
      for (int r = 0; r < 4; r++) begin
         peek($sformatf("rst_r%0d", r), 2'(r), 8'h00);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_regfile_wb.md
# alu_regfile_wb

Operand-supply and writeback stage wrapped around the combinational ALU. It holds a 4×8-bit register file and latches the two source operands onto the ALU's `R1`/`R2` inputs. It then selects one of the ALU's parallel result buses by opcode, commits that result to a destination register and updates the zero/overflow flags. Operation is a three-state handshake FSM. A separate load port preloads registers from the control path.

## Interface
- `NREGS`, 4: register count; address width is fixed at 2 bits; data width is fixed at 8.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  instruction request.
- `op_ready`  out  1  high only in IDLE; an instruction is accepted on an edge where `op_valid && op_ready`.
- `op_code`  in  3  000 ADD, 001 SHL, 010 SHR, 011 AND, 100 OR, 101 CMP, 110 MOV, 111 NOP.
- `rs1`, `rs2`, `rd`  in  2 each  source and destination register addresses.
- `ld_valid`  in  1  register load request.
- `ld_ready`  out  1  low only in WRITE.
- `ld_addr`  in  2  load address.
- `ld_data`  in  8  load data.
- `R1`, `R2`  out  8 each  operand registers driving the ALU.
- `Addition`, `MultiplyByTwo`, `DivideByTwo`, `And`, `Or`, `Compare`  in  8 each  ALU result buses.
- `AdditionOverflow`, `MultiplyByTwoOverflow`  in  1 each  ALU overflow flags.
- `wb_valid`  out  1  one-cycle pulse when a result commits.
- `wb_data`  out  8  last committed result.
- `flag_z`, `flag_v`  out  1 each  zero and overflow flags.

## Operation
- FSM states: IDLE, EXEC, WRITE.
  - IDLE → EXEC on accept.
  - EXEC → WRITE unconditionally.
  - WRITE → IDLE unconditionally.
- Accept edge:
  - Latch `op_code`, `rd`.
  - Load `R1` ← `regs[rs1]` and `R2` ← `regs[rs2]`, using pre-edge register values.
  - A load to the same address on that edge does not bypass into the operands.
- EXEC: `R1`/`R2` are stable and the ALU settles. No register-file write from the op.
- WRITE edge:
  - Result select by latched opcode: ADD→`Addition`, SHL→`MultiplyByTwo`, SHR→`DivideByTwo`, AND→`And`, OR→`Or`, CMP→`Compare`, MOV→`R2`.
  - For every opcode except NOP: `regs[rd]` ← result, `wb_data` ← result, `wb_valid` ← 1 for one cycle.
  - `flag_z` ← (result == 0).
  - `flag_v` ← `AdditionOverflow` for ADD, `MultiplyByTwoOverflow` for SHL, 0 otherwise.
  - NOP: no register write, flags unchanged, `wb_valid` stays 0, `wb_data` unchanged; the FSM still passes through WRITE.
- Load port:
  - On an edge with `ld_valid && ld_ready`, `regs[ld_addr]` ← `ld_data`.
  - Loads are legal in IDLE and EXEC, including the accept edge.
  - `ld_ready`=0 in WRITE, so a writeback and a load can never collide.
- `R1`/`R2` hold their values after WRITE until the next accept.
- Reset, asynchronous and immediate:
  - All registers, `R1`, `R2`, `wb_data`, `flag_z`, `flag_v`, `wb_valid` go to 0; state goes to IDLE.
  - `op_ready`=1 and `ld_ready`=1 while in reset and after it.
  - Reset during EXEC or WRITE aborts the op: no commit, and no `wb_valid` after release.

## Timing
- Accept at edge N.
  - EXEC during cycle N+1.
  - Commit at edge N+2.
  - `wb_valid` high during cycle N+2.
  - `op_ready` back high in cycle N+2.
- Next accept is possible at edge N+3. Throughput is one op per 3 cycles.
- `op_ready`, `ld_ready` are decoded combinationally from state only; there is no combinational path from `op_valid`.
- A result is readable as an operand by an op accepted at edge N+3 or later; no forwarding is required.
- A load at edge M is visible to an op accepted at edge M+1 or later.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-EXEC with an ADD pending → all outputs 0 and `op_ready`=1 immediately; after release, no `wb_valid` pulse and all regs read 0.
- **ADD, nonzero result:** load r0=100, r1=20; ADD rs1=0 rs2=1 rd=2 → after 3 cycles `wb_data`=120, `flag_z`=0, `flag_v`=0; a following MOV rs2=2 rd=3 → `wb_data`=120.
- **AND to zero:** load r0=0x0F, r1=0xF0; AND rd=0 → `wb_data`=0x00, `flag_z`=1, r0=0.
- **SHL with overflow, then NOP:** load r1=0x81; SHL rs2=1 rd=1 → `wb_data`=0x02, `flag_v`=1; a following NOP → no `wb_valid`, flags unchanged, FSM takes 3 cycles.
- **Load on accept edge:** load r0=0x55 and accept MOV rs2=0 on the same edge, with r0 previously 0x11 → result 0x11; `ld_valid` held through WRITE is deferred one cycle (`ld_ready`=0) and then lands.
- **Back-to-back ops:** hold `op_valid`=1 continuously → accepts exactly every 3 cycles and each `wb_valid` is a single-cycle pulse.
